clocked_demux: RTL and testbench



---
 rtl/clocked_mux_pkg.sv | 25 ++
 rtl/bs_to_twos.sv | 31 +++
 rtl/clocked_demux.sv | 225 ++++++++++++++++++++++
 tb/tb_clocked_demux.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clocked_mux_pkg.sv
// -----------------------------------------------------------------------------
// clocked_mux_pkg
//
// Shared definitions for the pos/neg time-multiplexed borrow-save datapath.
// Imported by clocked_demux and its helpers.
//
// Contents:
//   state_e  - demux pairing state (ST_EMPTY / ST_HAVE_POS)
//   phase_e  - phase tag carried alongside each multiplexed word
//              (PH_POS = pos word, PH_NEG = neg word)
// -----------------------------------------------------------------------------
package clocked_mux_pkg;

  // Pairing state of the demultiplexer: whether a pos word is waiting for
  // its matching neg word.
  typedef enum logic {
    ST_EMPTY    = 1'b0,
    ST_HAVE_POS = 1'b1
  } state_e;

  // Phase tag values as driven by the upstream multiplexer.
  localparam logic PH_POS = 1'b0;
  localparam logic PH_NEG = 1'b1;

endpackage : clocked_mux_pkg

// File: rtl/bs_to_twos.sv
// -----------------------------------------------------------------------------
// bs_to_twos
//
// Purely combinational borrow-save to two's-complement converter. A
// borrow-save value is held as two unsigned words whose difference is the
// represented number; this block forms that difference one bit wider than
// the inputs so that every result from -(2^WIDTH-1) to +(2^WIDTH-1) is exact.
//
// Parameters:
//   WIDTH - width of each pos/neg word
//
// Ports:
//   pos   in   WIDTH    positive-weight word (unsigned)
//   neg   in   WIDTH    negative-weight word (unsigned)
//   diff  out  WIDTH+1  signed pos - neg
// -----------------------------------------------------------------------------
module bs_to_twos #(
  parameter int WIDTH = 30
) (
  input  logic [WIDTH-1:0]        pos,
  input  logic [WIDTH-1:0]        neg,
  output logic signed [WIDTH:0]   diff
);

  // Both words are zero-extended before subtracting; the extra bit then acts
  // as the sign of the result, so no overflow is possible.
  always_comb begin
    diff = $signed({1'b0, pos}) - $signed({1'b0, neg});
  end

endmodule : bs_to_twos

// File: rtl/clocked_demux.sv
// -----------------------------------------------------------------------------
// clocked_demux
//
// Downstream stage of the fast_clock-domain pos/neg time-multiplexer. The
// single mux_in stream carries alternating pos and neg words of a
// borrow-save MSDF value, tagged by phase_in. This block re-pairs them,
// registers the pair together with its two's-complement value (pos - neg),
// and offers the result through a valid/ready output slot.
//
// Ordering errors (orphan neg word, duplicate pos word) raise a one-cycle
// phase_err pulse. A completed pair that finds the output slot still
// occupied is dropped and the sticky overflow flag is set.
//
// Configuration:
//   DEMUX_ERR_CNT_EN - when defined, err_count is a saturating counter of
//                      cycles with a phase error or a dropped pair. When not
//                      defined, err_count is tied to zero and no counter
//                      flops exist.
//
// Parameters:
//   WIDTH - width of mux_in and of each pos/neg word
//   CNT_W - width of err_count
//
// Ports:
//   fast_clock  in   1        sole clock, rising edge
//   reset       in   1        asynchronous, active-high reset
//   mux_in      in   WIDTH    time-multiplexed word stream
//   phase_in    in   1        0 = pos word, 1 = neg word
//   in_valid    in   1        mux_in / phase_in meaningful this cycle
//   out_ready   in   1        consumer accepts the held pair this cycle
//   clear_err   in   1        synchronous clear of overflow and err_count
//   out_valid   out  1        pos_out/neg_out/diff_out hold a valid pair
//   pos_out     out  WIDTH    captured pos word
//   neg_out     out  WIDTH    captured neg word
//   diff_out    out  WIDTH+1  signed pos_out - neg_out
//   phase_err   out  1        one-cycle pulse per mis-ordered input word
//   overflow    out  1        sticky: a complete pair was dropped
//   err_count   out  CNT_W    saturating error count (see configuration)
// -----------------------------------------------------------------------------
module clocked_demux
  import clocked_mux_pkg::*;
#(
  parameter int WIDTH = 30,
  parameter int CNT_W = 8
) (
  input  logic                    fast_clock,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        mux_in,
  input  logic                    phase_in,
  input  logic                    in_valid,
  input  logic                    out_ready,
  input  logic                    clear_err,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        pos_out,
  output logic [WIDTH-1:0]        neg_out,
  output logic signed [WIDTH:0]   diff_out,
  output logic                    phase_err,
  output logic                    overflow,
  output logic [CNT_W-1:0]        err_count
);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_e                 state_q,     state_d;
  logic [WIDTH-1:0]       pos_hold_q,  pos_hold_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       pos_out_q,   pos_out_d;
  logic [WIDTH-1:0]       neg_out_q,   neg_out_d;
  logic signed [WIDTH:0]  diff_out_q,  diff_out_d;
  logic                   phase_err_q, phase_err_d;
  logic                   overflow_q,  overflow_d;

  // Per-cycle events, decoded from the current state and input word.
  logic slot_free;   // output slot can take a new pair this cycle
  logic pair_done;   // a neg word completes a held pos word
  logic pair_load;   // completed pair goes into the output slot
  logic pair_drop;   // completed pair is lost because the slot is busy
  logic phase_bad;   // orphan neg word or duplicate pos word

  logic signed [WIDTH:0] pair_diff;

  // The value registered into diff_out is the held pos word minus the
  // incoming neg word, i.e. exactly the pair that completes this cycle.
  bs_to_twos #(
    .WIDTH (WIDTH)
  ) u_bs_to_twos (
    .pos  (pos_hold_q),
    .neg  (mux_in),
    .diff (pair_diff)
  );

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // The slot is free if it is empty or is being drained in this same
    // cycle; the latter lets a new pair replace an accepted one with no
    // bubble, giving one pair every two cycles.
    slot_free = !out_valid_q || out_ready;

    pair_done = in_valid && (state_q == ST_HAVE_POS) && (phase_in == PH_NEG);
    pair_load = pair_done && slot_free;
    pair_drop = pair_done && !slot_free;

    phase_bad = in_valid &&
                (((state_q == ST_EMPTY)    && (phase_in == PH_NEG)) ||
                 ((state_q == ST_HAVE_POS) && (phase_in == PH_POS)));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    pos_hold_d  = pos_hold_q;
    out_valid_d = out_valid_q;
    pos_out_d   = pos_out_q;
    neg_out_d   = neg_out_q;
    diff_out_d  = diff_out_q;
    phase_err_d = phase_bad;
    overflow_d  = overflow_q;

    // Pairing state. A pos word is always captured, whether it starts a
    // pair or replaces a stale one; a neg word always ends the pair attempt.
    if (in_valid) begin
      if (phase_in == PH_POS) begin
        pos_hold_d = mux_in;
        state_d    = ST_HAVE_POS;
      end else begin
        state_d    = ST_EMPTY;
      end
    end

    // Output slot. A load takes priority over a drain so that accept and
    // reload in the same cycle keeps out_valid high.
    if (pair_load) begin
      out_valid_d = 1'b1;
      pos_out_d   = pos_hold_q;
      neg_out_d   = mux_in;
      diff_out_d  = pair_diff;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Sticky drop flag; a clear in the same cycle as a drop wins.
    if (clear_err) begin
      overflow_d = 1'b0;
    end else if (pair_drop) begin
      overflow_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge fast_clock or posedge reset) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    if (reset) begin
      state_q     <= ST_EMPTY;
      pos_hold_q  <= '0;
      out_valid_q <= 1'b0;
      pos_out_q   <= '0;
      neg_out_q   <= '0;
      diff_out_q  <= '0;
      phase_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_hold_q  <= pos_hold_d;
      out_valid_q <= out_valid_d;
      pos_out_q   <= pos_out_d;
      neg_out_q   <= neg_out_d;
      diff_out_q  <= diff_out_d;
      phase_err_q <= phase_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional saturating error counter
  // ---------------------------------------------------------------------------
`ifdef DEMUX_ERR_CNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_event;

  // A phase error and a drop cannot both arise from one word, but the
  // counter is defined to step at most once per cycle regardless.
  always_comb begin
    err_event   = phase_bad || pair_drop;
    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = '0;
    end else if (err_event && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = {CNT_W{1'b0}};
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign pos_out   = pos_out_q;
  assign neg_out   = neg_out_q;
  assign diff_out  = diff_out_q;
  assign phase_err = phase_err_q;
  assign overflow  = overflow_q;

endmodule : clocked_demux

// File: tb/tb_clocked_demux.sv
// -----------------------------------------------------------------------------
// tb_clocked_demux
//
// Self-checking bench for clocked_demux. A directed vector table walks the
// main scenarios (pairing, negative differences, back-to-back delivery,
// drop/overflow, orphan and duplicate words, clear priority, counter
// saturation), a hand-written sequence exercises asynchronous reset in the
// middle of a pair, and a random phase compares every cycle against a
// queue-based reference model. err_count expectations follow the
// DEMUX_ERR_CNT_EN build option; CNT_W is set to 2 so saturation is reached
// quickly.
// -----------------------------------------------------------------------------
module tb_clocked_demux;

  localparam int WIDTH   = 30;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DEMUX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                   fast_clock = 1'b0;
  logic                   reset      = 1'b0;
  logic [WIDTH-1:0]       mux_in     = '0;
  logic                   phase_in   = 1'b0;
  logic                   in_valid   = 1'b0;
  logic                   out_ready  = 1'b0;
  logic                   clear_err  = 1'b0;
  logic                   out_valid;
  logic [WIDTH-1:0]       pos_out;
  logic [WIDTH-1:0]       neg_out;
  logic signed [WIDTH:0]  diff_out;
  logic                   phase_err;
  logic                   overflow;
  logic [CNT_W-1:0]       err_count;
  logic [WIDTH:0]         diff_u;

  assign diff_u = diff_out;

  clocked_demux #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .fast_clock (fast_clock),
    .reset      (reset),
    .mux_in     (mux_in),
    .phase_in   (phase_in),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .clear_err  (clear_err),
    .out_valid  (out_valid),
    .pos_out    (pos_out),
    .neg_out    (neg_out),
    .diff_out   (diff_out),
    .phase_err  (phase_err),
    .overflow   (overflow),
    .err_count  (err_count)
  );

  always #5 fast_clock = ~fast_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev,
                            input logic [WIDTH-1:0] ep, input logic [WIDTH-1:0] en,
                            input logic [WIDTH:0] ed, input logic eperr,
                            input logic eovf, input int ecnt);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".pos_out"},   64'(pos_out),   64'(ep));
    check({tag, ".neg_out"},   64'(neg_out),   64'(en));
    check({tag, ".diff_out"},  64'(diff_u),    64'(ed));
    check({tag, ".phase_err"}, 64'(phase_err), 64'(eperr));
    check({tag, ".overflow"},  64'(overflow),  64'(eovf));
    check({tag, ".err_count"}, 64'(err_count), CNT_EN ? 64'(ecnt) : 64'd0);
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic ph, input logic [WIDTH-1:0] d,
                       input logic rdy, input logic clr);
    in_valid  = v;
    phase_in  = ph;
    mux_in    = d;
    out_ready = rdy;
    clear_err = clr;
    @(posedge fast_clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    phase_in  = 1'b0;
    mux_in    = '0;
    out_ready = 1'b0;
    clear_err = 1'b0;
    reset     = 1'b1;
    @(posedge fast_clock);
    @(posedge fast_clock);
    #1;
    check_outs("reset", 1'b0, '0, '0, '0, 1'b0, 1'b0, 0);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue holds at most one waiting pos word; the output
  // slot, flags and counter follow the pairing and handshake rules directly.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] m_pend[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_pos, m_neg;
  logic [WIDTH:0]   m_diff;
  logic             m_perr, m_ovf;
  int               m_cnt;

  task automatic model_reset();
    m_pend.delete();
    m_valid = 1'b0;
    m_pos   = '0;
    m_neg   = '0;
    m_diff  = '0;
    m_perr  = 1'b0;
    m_ovf   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic v, input logic ph, input logic [WIDTH-1:0] d,
                            input logic rdy, input logic clr);
    bit               free, perr, drop, load;
    logic [WIDTH-1:0] p;
    longint           diff;
    free = !m_valid || rdy;
    perr = 0;
    drop = 0;
    load = 0;
    p    = '0;
    if (v) begin
      if (ph == 1'b0) begin
        if (m_pend.size() > 0) perr = 1;
        m_pend.delete();
        m_pend.push_back(d);
      end else if (m_pend.size() == 0) begin
        perr = 1;
      end else begin
        p = m_pend.pop_front();
        if (free) load = 1;
        else      drop = 1;
      end
    end
    if (load) begin
      m_valid = 1'b1;
      m_pos   = p;
      m_neg   = d;
      diff    = longint'(p) - longint'(d);
      m_diff  = diff[WIDTH:0];
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    m_perr = perr;
    m_ovf  = clr ? 1'b0 : (m_ovf | drop);
    if (clr)              m_cnt = 0;
    else if (perr || drop) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic             v;
    logic             ph;
    logic [WIDTH-1:0] d;
    logic             rdy;
    logic             clr;
    logic             ev;
    logic [WIDTH-1:0] ep;
    logic [WIDTH-1:0] en;
    logic [WIDTH:0]   ed;
    logic             eperr;
    logic             eovf;
    int               ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic ph, logic [WIDTH-1:0] d, logic rdy,
                              logic clr, logic ev, logic [WIDTH-1:0] ep,
                              logic [WIDTH-1:0] en, logic [WIDTH:0] ed,
                              logic eperr, logic eovf, int ecnt);
    vec_t r;
    r.v = v; r.ph = ph; r.d = d; r.rdy = rdy; r.clr = clr;
    r.ev = ev; r.ep = ep; r.en = en; r.ed = ed;
    r.eperr = eperr; r.eovf = eovf; r.ecnt = ecnt;
    return r;
  endfunction

  initial begin
    logic [WIDTH-1:0] rd;
    logic             rv, rph, rrdy, rclr;

    //                v  ph  data       rdy clr  ev  pos      neg      diff           perr ovf cnt
    tbl.push_back(mk(1, 0, 30'h0A,    1,  0,   0,  30'h0,   30'h0,   31'h0,          0,  0,  0)); // pos A
    tbl.push_back(mk(1, 1, 30'h03,    1,  0,   1,  30'hA,   30'h3,   31'h7,          0,  0,  0)); // A-3=+7
    tbl.push_back(mk(1, 0, 30'h01,    1,  0,   0,  30'hA,   30'h3,   31'h7,          0,  0,  0)); // drained
    tbl.push_back(mk(1, 1, 30'h05,    1,  0,   1,  30'h1,   30'h5,   31'h7FFFFFFC,   0,  0,  0)); // 1-5=-4
    tbl.push_back(mk(1, 0, 30'h10,    1,  0,   0,  30'h1,   30'h5,   31'h7FFFFFFC,   0,  0,  0)); // back-to-back
    tbl.push_back(mk(1, 1, 30'h04,    1,  0,   1,  30'h10,  30'h4,   31'hC,          0,  0,  0));
    tbl.push_back(mk(1, 0, 30'h20,    1,  0,   0,  30'h10,  30'h4,   31'hC,          0,  0,  0));
    tbl.push_back(mk(1, 1, 30'h08,    1,  0,   1,  30'h20,  30'h8,   31'h18,         0,  0,  0));
    tbl.push_back(mk(1, 0, 30'h30,    1,  0,   0,  30'h20,  30'h8,   31'h18,         0,  0,  0)); // slot empties
    tbl.push_back(mk(1, 1, 30'h06,    0,  0,   1,  30'h30,  30'h6,   31'h2A,         0,  0,  0)); // loads, held
    tbl.push_back(mk(1, 0, 30'h40,    0,  0,   1,  30'h30,  30'h6,   31'h2A,         0,  0,  0)); // stable
    tbl.push_back(mk(1, 1, 30'h07,    0,  0,   1,  30'h30,  30'h6,   31'h2A,         0,  1,  1)); // dropped
    tbl.push_back(mk(0, 0, 30'h0,     1,  0,   0,  30'h30,  30'h6,   31'h2A,         0,  1,  1)); // accepted
    tbl.push_back(mk(1, 1, 30'h55,    1,  0,   0,  30'h30,  30'h6,   31'h2A,         1,  1,  2)); // orphan neg
    tbl.push_back(mk(0, 0, 30'h0,     1,  0,   0,  30'h30,  30'h6,   31'h2A,         0,  1,  2)); // pulse ends
    tbl.push_back(mk(1, 0, 30'h02,    1,  0,   0,  30'h30,  30'h6,   31'h2A,         0,  1,  2));
    tbl.push_back(mk(1, 0, 30'h09,    1,  0,   0,  30'h30,  30'h6,   31'h2A,         1,  1,  3)); // dup pos
    tbl.push_back(mk(1, 1, 30'h04,    1,  0,   1,  30'h9,   30'h4,   31'h5,          0,  1,  3)); // newer pos used
    tbl.push_back(mk(0, 0, 30'h0,     0,  0,   1,  30'h9,   30'h4,   31'h5,          0,  1,  3));
    tbl.push_back(mk(1, 1, 30'h01,    1,  1,   0,  30'h9,   30'h4,   31'h5,          1,  0,  0)); // clear wins
    tbl.push_back(mk(0, 0, 30'h0,     1,  0,   0,  30'h9,   30'h4,   31'h5,          0,  0,  0));
    tbl.push_back(mk(1, 1, 30'h11,    1,  0,   0,  30'h9,   30'h4,   31'h5,          1,  0,  1)); // saturation
    tbl.push_back(mk(1, 1, 30'h12,    1,  0,   0,  30'h9,   30'h4,   31'h5,          1,  0,  2));
    tbl.push_back(mk(1, 1, 30'h13,    1,  0,   0,  30'h9,   30'h4,   31'h5,          1,  0,  3));
    tbl.push_back(mk(1, 1, 30'h14,    1,  0,   0,  30'h9,   30'h4,   31'h5,          1,  0,  3));
    tbl.push_back(mk(1, 1, 30'h15,    1,  0,   0,  30'h9,   30'h4,   31'h5,          1,  0,  3));
    tbl.push_back(mk(0, 0, 30'h0,     1,  0,   0,  30'h9,   30'h4,   31'h5,          0,  0,  3));
    tbl.push_back(mk(0, 0, 30'h0,     1,  1,   0,  30'h9,   30'h4,   31'h5,          0,  0,  0)); // clear

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].ph, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ep, tbl[i].en, tbl[i].ed,
                 tbl[i].eperr, tbl[i].eovf, tbl[i].ecnt);
    end

    // Asynchronous reset while a pos word is held and the slot is full.
    drive(1, 0, 30'h11, 0, 0);
    drive(1, 1, 30'h22, 0, 0);
    drive(1, 0, 30'h33, 0, 0);
    check("pre_rst.out_valid", 64'(out_valid), 64'd1);
    check("pre_rst.pos_out",   64'(pos_out),   64'h11);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, '0, '0, '0, 1'b0, 1'b0, 0);
    @(posedge fast_clock);
    #1;
    reset = 1'b0;
    drive(1, 1, 30'h44, 1, 0);
    check_outs("post_rst_orphan", 1'b0, '0, '0, '0, 1'b1, 1'b0, 1);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rv   = ($urandom_range(0, 3) != 0);
      rph  = ($urandom_range(0, 9) < 8) ? (m_pend.size() > 0) : (m_pend.size() == 0);
      rd   = WIDTH'($urandom());
      rrdy = ($urandom_range(0, 9) < 7);
      rclr = ($urandom_range(0, 49) == 0);
      model_step(rv, rph, rd, rrdy, rclr);
      drive(rv, rph, rd, rrdy, rclr);
      check_outs($sformatf("rnd%0d", i), m_valid, m_pos, m_neg, m_diff,
                 m_perr, m_ovf, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clocked_demux
